// File: rtl/fmps_test_packet_scheduler.sv
// fmps_test_packet_scheduler: FA-triggered burst sequencer driving the FMPS test-link packet writer,
// pacing each strobe on the previous packet's TLAST handshake with timeout and channel-loss abort.
module fmps_test_packet_scheduler #(
  parameter int COUNT_WIDTH    = 5,
  parameter int SPACING_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int OVERRUN_WIDTH  = 8
) (
  input  logic                     auroraUserClk,
  input  logic                     auroraUserReset_n,
  input  logic                     enable,
  input  logic [COUNT_WIDTH-1:0]   packetCount,
  input  logic [SPACING_WIDTH-1:0] packetSpacing,
  input  logic                     auroraFAstrobe,
  input  logic                     auroraChannelUp,
  input  logic                     tvalid,
  input  logic                     tready,
  input  logic                     tlast,
  output logic                     genPacketStrobe,
  output logic [COUNT_WIDTH-1:0]   packetIndex,
  output logic                     busy,
  output logic                     cycleDoneStrobe,
  output logic                     abortStrobe,
  output logic                     timeoutStrobe,
  output logic [15:0]              cyclesCompleted,
  output logic [OVERRUN_WIDTH-1:0] overrunCount
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, GAP, STROBE, WAIT_END} state_t;
  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d, issued_q, issued_d, idx_q, idx_d;
  logic [SPACING_WIDTH-1:0] spacing_q, spacing_d, gap_q, gap_d;
  logic [WW-1:0]            wait_q, wait_d;
  logic                     strobe_q, strobe_d, busy_q, busy_d;
  logic                     done_q, done_d, abort_q, abort_d, tmo_q, tmo_d;
  logic [15:0]              cycles_q, cycles_d;
  logic [OVERRUN_WIDTH-1:0] ovr_q, ovr_d;
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    spacing_d = spacing_q;
    gap_d     = gap_q;
    issued_d  = issued_q;
    wait_d    = wait_q;
    idx_d     = idx_q;
    cycles_d  = cycles_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    tmo_d     = 1'b0;
    ovr_d     = ovr_q + OVERRUN_WIDTH'(auroraFAstrobe && state_q != IDLE && ovr_q != '1);
    case (state_q)
      IDLE: if (auroraFAstrobe && enable && auroraChannelUp && packetCount != '0) begin
        count_d   = packetCount;
        spacing_d = packetSpacing;
        gap_d     = packetSpacing;
        issued_d  = '0;
        idx_d     = '0;
        state_d   = GAP;
      end
      GAP: if (gap_q == '0) begin
        strobe_d = 1'b1;
        state_d  = STROBE;
      end else gap_d = gap_q - 1'b1;
      STROBE: begin
        wait_d  = '0;
        state_d = WAIT_END;
      end
      WAIT_END: if (tvalid && tready && tlast) begin
        if (COUNT_WIDTH'(issued_q + 1'b1) == count_q) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          cycles_d = cycles_q + 16'd1;
        end else begin
          issued_d = COUNT_WIDTH'(issued_q + 1'b1);
          idx_d    = COUNT_WIDTH'(issued_q + 1'b1);
          gap_d    = spacing_q;
          state_d  = GAP;
        end
      end else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        abort_d = 1'b1;
        tmo_d   = 1'b1;
      end else wait_d = wait_q + 1'b1;
      default: state_d = IDLE;
    endcase
    // Channel loss overrides any completion or timeout decided above.
    if (state_q != IDLE && !auroraChannelUp) begin
      state_d  = IDLE;
      strobe_d = 1'b0;
      done_d   = 1'b0;
      tmo_d    = 1'b0;
      abort_d  = 1'b1;
      idx_d    = idx_q;
      cycles_d = cycles_q;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge auroraUserClk or negedge auroraUserReset_n)
    if (!auroraUserReset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      spacing_q <= '0;
      gap_q     <= '0;
      issued_q  <= '0;
      wait_q    <= '0;
      idx_q     <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      tmo_q     <= 1'b0;
      cycles_q  <= '0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      spacing_q <= spacing_d;
      gap_q     <= gap_d;
      issued_q  <= issued_d;
      wait_q    <= wait_d;
      idx_q     <= idx_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      tmo_q     <= tmo_d;
      cycles_q  <= cycles_d;
      ovr_q     <= ovr_d;
    end
  assign genPacketStrobe = strobe_q;
  assign packetIndex     = idx_q;
  assign busy            = busy_q;
  assign cycleDoneStrobe = done_q;
  assign abortStrobe     = abort_q;
  assign timeoutStrobe   = tmo_q;
  assign cyclesCompleted = cycles_q;
  assign overrunCount    = ovr_q;
endmodule

// File: tb/tb_fmps_test_packet_scheduler.sv
// tb_fmps_test_packet_scheduler: scenario tasks plus a strobe scoreboard fed by the FA driver and the TLAST sink.
module tb_fmps_test_packet_scheduler;
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b1, fa = 1'b0, up = 1'b1;
  logic        tvalid, tready, tlast;
  logic [4:0]  pcount = '0;
  logic [7:0]  pspace = '0;
  logic        strobe, busy, done, abrt, tmo;
  logic [4:0]  pidx;
  logic [15:0] cycles;
  logic [7:0]  ovr;
  int cyc = 0, errors = 0, checks = 0;
  int n_strobe = 0, n_done = 0, n_abort = 0, n_tmo = 0, last_strobe_cyc = 0, last_abort_cyc = 0;
  int sink_left = 0, s_count = 0, s_spacing = 0;
  logic [4:0] sink_idx = '0;
  typedef struct {logic [4:0] idx; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;

  fmps_test_packet_scheduler #(.TIMEOUT_CYCLES(16)) dut (
    .auroraUserClk(clk), .auroraUserReset_n(rst_n), .enable(enable),
    .packetCount(pcount), .packetSpacing(pspace), .auroraFAstrobe(fa),
    .auroraChannelUp(up), .tvalid(tvalid), .tready(tready), .tlast(tlast),
    .genPacketStrobe(strobe), .packetIndex(pidx), .busy(busy),
    .cycleDoneStrobe(done), .abortStrobe(abrt), .timeoutStrobe(tmo),
    .cyclesCompleted(cycles), .overrunCount(ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every strobe must match the next expected (index, cycle).
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (strobe) begin
        n_strobe++;
        last_strobe_cyc = cyc;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: index=%0d cycle=%0d, required no strobe", pidx, cyc);
        end else begin
          e = q.pop_front();
          if (pidx !== e.idx || cyc != e.cyc) begin
            errors++;
            $display("FAIL strobe: index=%0d cycle=%0d, required index=%0d cycle=%0d", pidx, cyc, e.idx, e.cyc);
          end
        end
      end
      if (done) n_done++;
      if (abrt) begin n_abort++; last_abort_cyc = cyc; end
      if (tmo) n_tmo++;
    end
  end

  // Sink: stray TLAST in STROBE cycle, tlast=0 beat, then a real TLAST handshake 4 clocks after the strobe.
  initial begin
    tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && strobe && sink_left > 0) begin
        tvalid = 1'b1; tready = 1'b1; tlast = 1'b1;
        @(negedge clk);
        tlast = 1'b0;
        @(negedge clk);
        tvalid = 1'b0; tready = 1'b0;
        @(negedge clk);
        tvalid = 1'b1; tready = 1'b1; tlast = 1'b1;
        @(negedge clk);
        tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
        sink_left--;
        sink_idx++;
        if (int'(sink_idx) < s_count) q.push_back('{sink_idx, cyc + s_spacing + 1});
      end
    end
  end

  task automatic pulse_fa(input logic starts);
    @(negedge clk);
    if (starts) q.push_back('{5'd0, cyc + int'(pspace) + 2});
    fa = 1'b1;
    @(negedge clk);
    fa = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n); end
    @(negedge clk);
  endtask

  task automatic setup(input int cnt, input int sp, input int sink);
    pcount = 5'(cnt); pspace = 8'(sp); s_count = cnt; s_spacing = sp;
    sink_idx = '0; sink_left = sink;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({strobe, busy, done, abrt, tmo} !== 5'b0) begin errors++; $display("FAIL reset_flags: %b, required 00000", {strobe, busy, done, abrt, tmo}); end
    checks++; if (pidx !== 5'd0) begin errors++; $display("FAIL reset_index: %0d, required 0", pidx); end
    checks++; if (cycles !== 16'd0) begin errors++; $display("FAIL reset_cycles: %0d, required 0", cycles); end
    checks++; if (ovr !== 8'd0) begin errors++; $display("FAIL reset_overrun: %0d, required 0", ovr); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: %b, required 0", busy); end
  endtask

  task automatic test_normal();
    int b_str = n_strobe, b_done = n_done, b_ab = n_abort;
    setup(8, 8, 8);
    pulse_fa(1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_trigger: %b, required 1", busy); end
    pcount = 5'd3; pspace = 8'd1;
    wait_idle(3000);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL normal_pending: %0d strobes missing, required 0", q.size()); end
    checks++; if (n_strobe - b_str != 8) begin errors++; $display("FAIL normal_strobes: %0d, required 8", n_strobe - b_str); end
    checks++; if (n_done - b_done != 1) begin errors++; $display("FAIL normal_done: %0d, required 1", n_done - b_done); end
    checks++; if (n_abort != b_ab) begin errors++; $display("FAIL normal_abort: %0d, required 0", n_abort - b_ab); end
    checks++; if (cycles !== 16'd1) begin errors++; $display("FAIL normal_cycles: %0d, required 1", cycles); end
    checks++; if (pidx !== 5'd7) begin errors++; $display("FAIL normal_index_hold: %0d, required 7", pidx); end
  endtask

  task automatic test_zero();
    int b_str, b_done = n_done;
    logic seen = 1'b0;
    setup(2, 0, 2);
    pulse_fa(1'b1);
    wait_idle(500);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL zero_spacing_pending: %0d, required 0", q.size()); end
    checks++; if (n_done - b_done != 1) begin errors++; $display("FAIL zero_spacing_done: %0d, required 1", n_done - b_done); end
    checks++; if (cycles !== 16'd2) begin errors++; $display("FAIL zero_spacing_cycles: %0d, required 2", cycles); end
    b_str = n_strobe;
    setup(0, 3, 0);
    pulse_fa(1'b0);
    repeat (8) begin seen |= busy; @(negedge clk); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL zero_count_busy: %b, required 0", seen); end
    checks++; if (n_strobe != b_str || cycles !== 16'd2) begin errors++; $display("FAIL zero_count_effect: strobes=%0d cycles=%0d, required 0 and 2", n_strobe - b_str, cycles); end
  endtask

  task automatic test_timeout();
    int b_str = n_strobe, b_tmo = n_tmo, b_ab = n_abort, b_done = n_done;
    logic [15:0] c0 = cycles;
    setup(4, 2, 1);
    pulse_fa(1'b1);
    wait_idle(500);
    checks++; if (n_strobe - b_str != 2) begin errors++; $display("FAIL timeout_strobes: %0d, required 2", n_strobe - b_str); end
    checks++; if (n_tmo - b_tmo != 1 || n_abort - b_ab != 1) begin errors++; $display("FAIL timeout_pulses: tmo=%0d abort=%0d, required 1 and 1", n_tmo - b_tmo, n_abort - b_ab); end
    // Abort lands 16 clocks after the one-clock strobe pulse ends.
    checks++; if (last_abort_cyc - last_strobe_cyc != 17) begin errors++; $display("FAIL timeout_latency: %0d, required 17", last_abort_cyc - last_strobe_cyc); end
    checks++; if (n_done != b_done || cycles !== c0) begin errors++; $display("FAIL timeout_completion: done=%0d cycles=%0d, required 0 and %0d", n_done - b_done, cycles, c0); end
    setup(1, 1, 1);
    pulse_fa(1'b1);
    wait_idle(500);
    checks++; if (q.size() != 0 || cycles !== c0 + 16'd1) begin errors++; $display("FAIL timeout_fresh_burst: pending=%0d cycles=%0d, required 0 and %0d", q.size(), cycles, c0 + 16'd1); end
  endtask

  task automatic test_channel_drop();
    int b_str = n_strobe, n = 0;
    logic seen = 1'b0;
    logic [7:0] o0 = ovr;
    setup(5, 10, 5);
    pulse_fa(1'b1);
    while (sink_idx < 5'd2 && n < 500) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    up = 1'b0;
    @(negedge clk);
    checks++; if ({busy, abrt, tmo} !== 3'b010) begin errors++; $display("FAIL drop_abort: busy/abort/timeout=%b, required 010", {busy, abrt, tmo}); end
    checks++; if (pidx !== 5'd2) begin errors++; $display("FAIL drop_index: %0d, required 2", pidx); end
    q.delete();
    sink_left = 0;
    repeat (20) @(negedge clk);
    pulse_fa(1'b0);
    repeat (15) begin seen |= busy; @(negedge clk); end
    checks++; if (n_strobe - b_str != 2 || seen !== 1'b0) begin errors++; $display("FAIL drop_quiet: strobes=%0d busy=%b, required 2 and 0", n_strobe - b_str, seen); end
    checks++; if (ovr !== o0) begin errors++; $display("FAIL drop_overrun: %0d, required %0d", ovr, o0); end
    up = 1'b1;
  endtask

  task automatic test_overrun();
    int b_str = n_strobe, b_done = n_done;
    logic [15:0] c0 = cycles;
    logic seen = 1'b0;
    setup(3, 255, 3);
    pulse_fa(1'b1);
    enable = 1'b0;
    for (int i = 0; i < 300; i++) begin @(negedge clk); fa = 1'b1; @(negedge clk); fa = 1'b0; end
    checks++; if (ovr !== 8'd255) begin errors++; $display("FAIL overrun_saturate: %0d, required 255", ovr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL overrun_busy: %b, required 1", busy); end
    wait_idle(2000);
    checks++; if (n_done - b_done != 1 || cycles !== c0 + 16'd1) begin errors++; $display("FAIL overrun_done: done=%0d cycles=%0d, required 1 and %0d", n_done - b_done, cycles, c0 + 16'd1); end
    checks++; if (n_strobe - b_str != 3 || q.size() != 0) begin errors++; $display("FAIL overrun_no_restart: strobes=%0d pending=%0d, required 3 and 0", n_strobe - b_str, q.size()); end
    pulse_fa(1'b0);
    repeat (6) begin seen |= busy; @(negedge clk); end
    checks++; if (seen !== 1'b0 || ovr !== 8'd255) begin errors++; $display("FAIL disabled_fa: busy=%b overrun=%0d, required 0 and 255", seen, ovr); end
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    int b, n = 0, b_done;
    setup(2, 1, 0);
    b = n_strobe;
    pulse_fa(1'b1);
    while (n_strobe == b && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({strobe, busy, done, abrt, tmo} !== 5'b0) begin errors++; $display("FAIL async_reset_flags: %b, required 00000", {strobe, busy, done, abrt, tmo}); end
    checks++; if (cycles !== 16'd0 || ovr !== 8'd0 || pidx !== 5'd0) begin errors++; $display("FAIL async_reset_counters: cycles=%0d overrun=%0d index=%0d, required 0 0 0", cycles, ovr, pidx); end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    b_done = n_done;
    setup(2, 3, 2);
    pulse_fa(1'b1);
    wait_idle(500);
    checks++; if (cycles !== 16'd1 || n_done - b_done != 1 || q.size() != 0) begin errors++; $display("FAIL post_reset_burst: cycles=%0d done=%0d pending=%0d, required 1 1 0", cycles, n_done - b_done, q.size()); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero();
    test_timeout();
    test_channel_drop();
    test_overrun();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
